// File: rtl/rdma_meta_ingress_mux.sv
// Per-channel metadata FIFOs merged onto one registered stream by a round-robin arbiter.
// Disabled channels keep buffering but are skipped until re-enabled.
module rdma_meta_ingress_mux #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 160,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_CH-1:0]          s_axis_tvalid,
    output logic [N_CH-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [CH_W-1:0]          m_axis_tid,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    input  logic [N_CH-1:0]          ch_enable,
    output logic [N_CH*CNT_W-1:0]    ch_occupancy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem    [N_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [N_CH];
    logic [PTR_W-1:0]  rd_ptr [N_CH];
    logic [CNT_W-1:0]  occ    [N_CH];
    logic [N_CH-1:0]   push;
    logic [N_CH-1:0]   pop;
    logic [N_CH-1:0]   eligible;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   grant;
    logic              grant_valid;
    logic              load;

    // Ready comes from registered occupancy only, so it never depends on the output side.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            s_axis_tready[i]               = !rst && (occ[i] < CNT_W'(DEPTH));
            eligible[i]                    = (occ[i] != '0) && ch_enable[i];
            ch_occupancy[i*CNT_W +: CNT_W] = occ[i];
        end
    end

    assign push = s_axis_tvalid & s_axis_tready;

    always_comb begin : arb
        int unsigned     idx;
        logic [CH_W-1:0] cand;
        idx         = 0;
        cand        = '0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx  = (32'(last_grant) + k) % N_CH;
            cand = CH_W'(idx);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
    end

    assign load = grant_valid && (!m_axis_tvalid || m_axis_tready);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pop[i] = load && (grant == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= s_axis_tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                occ[i]    <= '0;
            end else begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   occ[i] <= occ[i] + CNT_W'(1);
                    2'b01:   occ[i] <= occ[i] - CNT_W'(1);
                    default: occ[i] <= occ[i];
                endcase
            end
        end
    end

    // Output stage: holds while stalled, drops valid once consumed with nothing eligible.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tid    <= '0;
            last_grant    <= CH_W'(N_CH - 1);
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= mem[grant][rd_ptr[grant]];
            m_axis_tid    <= grant;
            last_grant    <= grant;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rdma_meta_ingress_mux.sv
// Bench for rdma_meta_ingress_mux: fixed vector table, directed corner sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_rdma_meta_ingress_mux;
    localparam int N_CH   = 4;
    localparam int DATA_W = 160;
    localparam int DEPTH  = 8;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH*DATA_W-1:0] s_axis_tdata;
    logic [N_CH-1:0]        s_axis_tvalid;
    logic [N_CH-1:0]        s_axis_tready;
    logic [DATA_W-1:0]      m_axis_tdata;
    logic [CH_W-1:0]        m_axis_tid;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic [N_CH-1:0]        ch_enable;
    logic [N_CH*CNT_W-1:0]  ch_occupancy;

    always #5 clk = ~clk;

    rdma_meta_ingress_mux #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tid   (m_axis_tid),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .ch_enable    (ch_enable),
        .ch_occupancy (ch_occupancy)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: one queue per channel plus the output register contents.
    logic [DATA_W-1:0] mq [N_CH][$];
    bit                mv;
    logic [DATA_W-1:0] md;
    int                mid;
    int                mlast;
    bit                acc [N_CH];

    bit                fire;
    logic [DATA_W-1:0] fire_data;
    logic [DATA_W-1:0] got [$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_edge();
        int winner;
        int c;
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                mq[i].delete();
                acc[i] = 0;
            end
            mv = 0; md = '0; mid = 0; mlast = N_CH - 1;
            return;
        end
        for (int i = 0; i < N_CH; i++) acc[i] = s_axis_tvalid[i] && (mq[i].size() < DEPTH);
        if (!mv || m_axis_tready) begin
            winner = -1;
            for (int k = 1; k <= N_CH; k++) begin
                c = (mlast + k) % N_CH;
                if (winner < 0 && ch_enable[c] && mq[c].size() > 0) winner = c;
            end
            if (winner >= 0) begin
                md = mq[winner].pop_front();
                mid = winner; mv = 1; mlast = winner;
            end else begin
                mv = 0;
            end
        end
        for (int i = 0; i < N_CH; i++)
            if (acc[i]) mq[i].push_back(s_axis_tdata[i*DATA_W +: DATA_W]);
    endtask

    task automatic compare_model();
        logic [N_CH-1:0]       er;
        logic [N_CH*CNT_W-1:0] eo;
        for (int i = 0; i < N_CH; i++) begin
            er[i] = !rst && (mq[i].size() < DEPTH);
            eo[i*CNT_W +: CNT_W] = CNT_W'(mq[i].size());
        end
        check("model_ready", s_axis_tready, er);
        check("model_occ", ch_occupancy, eo);
        check("model_valid", m_axis_tvalid, mv);
        if (mv) begin
            check("model_data", m_axis_tdata, md);
            check("model_tid", m_axis_tid, mid);
        end
    endtask

    task automatic step();
        fire      = m_axis_tvalid && m_axis_tready;
        fire_data = m_axis_tdata;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
        if (fire) got.push_back(fire_data);
    endtask

    task automatic set_word(input int ch, input logic [DATA_W-1:0] w);
        s_axis_tdata[ch*DATA_W +: DATA_W] = w;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] v;
        logic [7:0] w;
        logic [3:0] en;
        bit         mr;
        bit         ev;
        int         etid;
        logic [7:0] ew;
        logic [3:0] erdy;
        logic [15:0] eocc;
    } vec_t;

    vec_t tbl [21];

    initial begin
        int idx;
        tbl[0]  = '{1, 4'h0, 8'h00, 4'hf, 1, 0, 0, 8'h00, 4'h0, 16'h0000};
        tbl[1]  = '{0, 4'h0, 8'h00, 4'hf, 1, 0, 0, 8'h00, 4'hf, 16'h0000};
        tbl[2]  = '{0, 4'h4, 8'hA5, 4'hf, 1, 0, 0, 8'h00, 4'hf, 16'h0100};
        tbl[3]  = '{0, 4'h0, 8'h00, 4'hf, 1, 1, 2, 8'hA5, 4'hf, 16'h0000};
        tbl[4]  = '{0, 4'h0, 8'h00, 4'hf, 1, 0, 0, 8'h00, 4'hf, 16'h0000};
        tbl[5]  = '{0, 4'hf, 8'h11, 4'hf, 1, 0, 0, 8'h00, 4'hf, 16'h1111};
        tbl[6]  = '{0, 4'hf, 8'h22, 4'hf, 1, 1, 3, 8'h11, 4'hf, 16'h1222};
        tbl[7]  = '{0, 4'h0, 8'h00, 4'hf, 1, 1, 0, 8'h11, 4'hf, 16'h1221};
        tbl[8]  = '{0, 4'h0, 8'h00, 4'hf, 1, 1, 1, 8'h11, 4'hf, 16'h1211};
        tbl[9]  = '{0, 4'h0, 8'h00, 4'hf, 1, 1, 2, 8'h11, 4'hf, 16'h1111};
        tbl[10] = '{0, 4'h0, 8'h00, 4'hf, 1, 1, 3, 8'h22, 4'hf, 16'h0111};
        tbl[11] = '{0, 4'h0, 8'h00, 4'hf, 1, 1, 0, 8'h22, 4'hf, 16'h0110};
        tbl[12] = '{0, 4'h0, 8'h00, 4'hf, 1, 1, 1, 8'h22, 4'hf, 16'h0100};
        tbl[13] = '{0, 4'h0, 8'h00, 4'hf, 1, 1, 2, 8'h22, 4'hf, 16'h0000};
        tbl[14] = '{0, 4'h0, 8'h00, 4'hf, 1, 0, 0, 8'h00, 4'hf, 16'h0000};
        tbl[15] = '{0, 4'h2, 8'h33, 4'hd, 0, 0, 0, 8'h00, 4'hf, 16'h0010};
        tbl[16] = '{0, 4'h2, 8'h44, 4'hd, 0, 0, 0, 8'h00, 4'hf, 16'h0020};
        tbl[17] = '{0, 4'h0, 8'h00, 4'hf, 0, 1, 1, 8'h33, 4'hf, 16'h0010};
        tbl[18] = '{0, 4'h0, 8'h00, 4'hf, 0, 1, 1, 8'h33, 4'hf, 16'h0010};
        tbl[19] = '{0, 4'h0, 8'h00, 4'hf, 1, 1, 1, 8'h44, 4'hf, 16'h0000};
        tbl[20] = '{0, 4'h0, 8'h00, 4'hf, 1, 0, 0, 8'h00, 4'hf, 16'h0000};

        s_axis_tdata = '0;
        for (int r = 0; r < 21; r++) begin
            rst           = tbl[r].rst;
            s_axis_tvalid = tbl[r].v;
            for (int i = 0; i < N_CH; i++) set_word(i, DATA_W'(tbl[r].w));
            ch_enable     = tbl[r].en;
            m_axis_tready = tbl[r].mr;
            if (r == 1) begin
                #1;
                check("ready_after_rst", s_axis_tready, 4'hf);
            end
            step();
            check("tbl_valid", m_axis_tvalid, tbl[r].ev);
            check("tbl_ready", s_axis_tready, tbl[r].erdy);
            check("tbl_occ", ch_occupancy, tbl[r].eocc);
            if (tbl[r].ev || tbl[r].rst) begin
                check("tbl_tid", m_axis_tid, tbl[r].etid);
                check("tbl_data", m_axis_tdata, DATA_W'(tbl[r].ew));
            end
        end

        // Fill ch0 past its FIFO while the output is stalled, then drain in order.
        m_axis_tready = 0;
        ch_enable     = 4'hf;
        for (int k = 0; k < 9; k++) begin
            s_axis_tvalid = 4'b0001;
            set_word(0, DATA_W'(100 + k));
            check("full_push_ready", s_axis_tready[0], 1'b1);
            step();
        end
        s_axis_tvalid = 4'b0001;
        set_word(0, DATA_W'(999));
        #1;
        check("full_ready_low", s_axis_tready[0], 1'b0);
        check("full_occ", ch_occupancy[3:0], 4'd8);
        check("full_out_held", m_axis_tdata, DATA_W'(100));
        step();
        s_axis_tvalid = 0;
        m_axis_tready = 1;
        got.delete();
        for (int c = 0; c < 30 && got.size() < 9; c++) step();
        check("full_drain_count", got.size(), 9);
        for (int k = 0; k < got.size(); k++) check("full_drain_order", got[k], DATA_W'(100 + k));

        // 3*DEPTH words through ch1 with random backpressure: pointer wrap.
        got.delete();
        idx = 0;
        for (int c = 0; c < 600 && got.size() < 3 * DEPTH; c++) begin
            s_axis_tvalid = (idx < 3 * DEPTH) ? 4'b0010 : 4'b0000;
            set_word(1, DATA_W'(1000 + idx));
            m_axis_tready = 1'($urandom_range(0, 1));
            step();
            if (acc[1]) idx++;
        end
        check("wrap_count", got.size(), 3 * DEPTH);
        for (int k = 0; k < got.size(); k++) check("wrap_order", got[k], DATA_W'(1000 + k));
        check("wrap_occ_zero", ch_occupancy[7:4], 4'd0);

        // Mid-stream reset with words buffered and output stalled.
        s_axis_tvalid = 0;
        m_axis_tready = 1;
        step();
        step();
        m_axis_tready = 0;
        for (int k = 0; k < 5; k++) begin
            s_axis_tvalid = 4'b1000;
            set_word(3, DATA_W'(500 + k));
            step();
        end
        s_axis_tvalid = 0;
        check("rst_pre_valid", m_axis_tvalid, 1'b1);
        check("rst_pre_occ", ch_occupancy[15:12], 4'd4);
        rst = 1;
        step();
        check("rst_valid_low", m_axis_tvalid, 1'b0);
        check("rst_occ_zero", ch_occupancy, 16'h0000);
        rst = 0;
        m_axis_tready = 1;
        s_axis_tvalid = 4'b0001;
        set_word(0, DATA_W'(777));
        step();
        s_axis_tvalid = 0;
        got.delete();
        for (int c = 0; c < 10 && got.size() == 0; c++) step();
        check("rst_post_count", got.size(), 1);
        if (got.size() > 0) check("rst_post_word", got[0], DATA_W'(777));

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            s_axis_tvalid = 4'($urandom);
            for (int i = 0; i < N_CH; i++)
                set_word(i, {$urandom, $urandom, $urandom, $urandom, $urandom});
            ch_enable     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
            m_axis_tready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rdma_meta_ingress_mux.md
RDMA_META_INGRESS_MUX -- requirements
Module: rdma_meta_ingress_mux

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- N_CH, 4, number of metadata input channels (2..16).
- DATA_W, 160, metadata word width in bits.
- DEPTH, 8, per-channel FIFO depth in words (power of two, >=2).
- Derived: CH_W = max(1, clog2(N_CH)); CNT_W = clog2(DEPTH)+1.
REQ-002 Ports, one per line (name, direction, width, meaning); clock and reset first:
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, reset, synchronous, active-high.
- s_axis_tdata, in, N_CH*DATA_W, channel i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tvalid, in, N_CH, per-channel valid.
- s_axis_tready, out, N_CH, per-channel ready.
- m_axis_tdata, out, DATA_W, merged metadata word.
- m_axis_tid, out, CH_W, source channel index of m_axis_tdata.
- m_axis_tvalid, out, 1, merged valid.
- m_axis_tready, in, 1, merged ready.
- ch_enable, in, N_CH, per-channel arbitration enable.
- ch_occupancy, out, N_CH*CNT_W, per-channel FIFO fill level, channel i at [i*CNT_W +: CNT_W].
REQ-003 The block SHALL use one clock (clk) and a synchronous, active-high reset (rst); no other clock or reset input exists.

Function
REQ-004 Each channel SHALL own a DEPTH-word FIFO; a word is written when s_axis_tvalid[i] & s_axis_tready[i] at a rising edge.
REQ-005 s_axis_tready[i] SHALL equal (occupancy[i] < DEPTH), derived from registered occupancy only; never dependent on m_axis_tready.
REQ-006 A FIFO pop and push in the same cycle SHALL leave occupancy unchanged; occupancy SHALL never exceed DEPTH nor underflow below 0.
REQ-007 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated word.
REQ-008 Output SHALL be a registered stage: m_axis_tdata/tid/tvalid driven from flops only.
REQ-009 Output register SHALL load when (!m_axis_tvalid) or (m_axis_tvalid & m_axis_tready) and an eligible channel exists; eligible = occupancy[i] != 0 & ch_enable[i].
REQ-010 While m_axis_tvalid & !m_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid SHALL hold stable.
REQ-011 Minimum latency: word written at edge E0 SHALL be visible on m_axis after edge E1 (one cycle later); no combinational fall-through.
REQ-012 Sustained throughput SHALL be one word per cycle while eligible data exists and m_axis_tready=1.
REQ-013 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod N_CH, first eligible channel wins, last_grant updates to the winner on each load.
REQ-014 Disabled channels (ch_enable[i]=0) SHALL still accept input until full but SHALL never be granted; re-enable resumes in FIFO order.
REQ-015 Per-channel word order SHALL be preserved end to end.
REQ-016 m_axis_tvalid SHALL deassert after the last eligible word is consumed when no eligible channel remains.
REQ-017 ch_occupancy SHALL report the registered FIFO count, including the word popped into the output register no longer counted.

Reset
REQ-018 While rst=1: all occupancies 0, FIFO pointers 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tid 0, s_axis_tready all 0, last_grant = N_CH-1 (channel 0 first priority).
REQ-019 s_axis_tready[i] SHALL be 1 in the first cycle after rst deasserts.
REQ-020 Reset asserted mid-operation SHALL discard all buffered and output-held words at the next rising edge; no word emitted afterwards from pre-reset contents.

Verification
REQ-021 Single word: ch2 sends 0xA5 at E0, m_axis_tready=1 -> m_axis_tvalid=1, tdata=0xA5, tid=2 after E1; tvalid=0 after E2.
REQ-022 Fairness: all 4 channels continuously valid, tready=1 -> tid sequence 0,1,2,3,0,1,... with no repeats.
REQ-023 Full/backpressure: tready=0, ch0 pushes 9 words (DEPTH=8) -> 8 accepted into FIFO plus 1 in output register, s_axis_tready[0]=0, occupancy=8; release tready -> 9 words out in push order.
REQ-024 Wrap-around: 3*DEPTH words through ch1 with random tready -> all received in order, occupancy returns to 0.
REQ-025 Mask: ch_enable=4'b1101, ch1 holds 3 words -> no tid=1 emitted, occupancy[1]=3; set ch_enable[1]=1 -> ch1 words emitted in order.
REQ-026 Mid-stream reset: rst pulsed with 5 words buffered and tvalid held -> tvalid=0, all occupancy 0 after rst edge; next output is first post-reset word.
